// File: rtl/viola_pkg.sv
// Shared types and constants for the in-order commit scheduler (rob_commit_ctrl).
// Tag 0 means "no dependency"; live tags run 1..DEPTH and wrap.
package viola_pkg;

  localparam int TAG_W  = 3;
  localparam int DEPTH  = (1 << TAG_W) - 1;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  localparam logic [TAG_W-1:0] NO_DEP    = '0;
  localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              ready;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  // Successor of a live tag, wrapping DEPTH back to 1 (never yields NO_DEP).
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (t == LAST_TAG) ? FIRST_TAG : t + FIRST_TAG;
  endfunction

  // Entry i carries tag i+1.
  function automatic logic [TAG_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
    return t - FIRST_TAG;
  endfunction

endpackage

// File: rtl/rob_tag_ptr.sv
// Wrapping 1..DEPTH tag pointer used for both the ROB head and tail.
// rst and clr both return the pointer to tag 1.
module rob_tag_ptr
  import viola_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [TAG_W-1:0] ptr
);

  // NOTE: state registers are written with non-blocking assignments only,
  // so every always_ff sees pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= FIRST_TAG;
    end else if (inc) begin
      ptr <= next_tag(ptr);
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order commit scheduler: tags issued instructions, collects tagged results
// out of order and retires them in program order. Optional same-edge
// writeback->commit bypass is enabled by defining ROB_WB_BYPASS_EN.
module rob_commit_ctrl
  import viola_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [RD_W-1:0]   issue_rd,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  output logic              commit,
  output logic [RD_W-1:0]   reg_num,
  output logic [DATA_W-1:0] data_in,
  output logic [TAG_W-1:0]  num_in,
  output logic [TAG_W-1:0]  count
);

  rob_entry_t entries [DEPTH];

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  rob_entry_t        head_ent;
  logic              do_issue;
  logic              wb_hit;
  logic              head_ready;
  logic              do_retire;
  logic [DATA_W-1:0] retire_data;

  rob_tag_ptr u_head_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (do_retire),
    .ptr (head)
  );

  rob_tag_ptr u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (do_issue),
    .ptr (tail)
  );

  assign issue_tag = tail;
  assign head_ent  = entries[tag_idx(head)];

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    issue_ready = 1'b0;
    do_issue    = 1'b0;
    wb_hit      = 1'b0;
    head_ready  = 1'b0;
    retire_data = '0;
    do_retire   = 1'b0;

    // A full ROB stays closed even if the head retires this cycle.
    issue_ready = (count < LAST_TAG) && !flush && !rst;
    do_issue    = issue_valid && issue_ready;
    wb_hit      = wb_valid && (wb_tag != NO_DEP) && entries[tag_idx(wb_tag)].valid;

`ifdef ROB_WB_BYPASS_EN
    if (wb_hit && (wb_tag == head)) begin
      head_ready  = 1'b1;
      retire_data = wb_data;
    end else begin
      head_ready  = head_ent.ready;
      retire_data = head_ent.data;
    end
`else
    head_ready  = head_ent.ready;
    retire_data = head_ent.data;
`endif

    do_retire = head_ent.valid && head_ready && !flush && !rst;
  end

  // NOTE: the entry array is reset explicitly because the valid bits define
  // occupancy; it is only DEPTH words, so clearing whole entries is cheap.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (wb_hit) begin
        entries[tag_idx(wb_tag)].ready <= 1'b1;
        entries[tag_idx(wb_tag)].data  <= wb_data;
      end
      // Retire after writeback so a late result cannot resurrect a freed slot.
      if (do_retire) begin
        entries[tag_idx(head)].valid <= 1'b0;
        entries[tag_idx(head)].ready <= 1'b0;
      end
      if (do_issue) begin
        entries[tag_idx(tail)] <= '{valid: 1'b1, ready: 1'b0, rd: issue_rd, data: '0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      count <= count + TAG_W'(do_issue) - TAG_W'(do_retire);
    end
  end

  // Writes to x0 free their slot but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit  <= 1'b0;
      reg_num <= '0;
      data_in <= '0;
      num_in  <= '0;
    end else if (flush) begin
      commit <= 1'b0;
    end else begin
      commit <= do_retire && (head_ent.rd != '0);
      if (do_retire && (head_ent.rd != '0)) begin
        reg_num <= head_ent.rd;
        data_in <= retire_data;
        num_in  <= head;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios plus a randomized
// run against a queue-based program-order model. Honors ROB_WB_BYPASS_EN.
module tb_rob_commit_ctrl;
  import viola_pkg::*;

`ifdef ROB_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              issue_ready;
  logic [2:0]        issue_tag;
  logic              wb_valid;
  logic [2:0]        wb_tag;
  logic [31:0]       wb_data;
  logic              commit;
  logic [4:0]        reg_num;
  logic [31:0]       data_in;
  logic [2:0]        num_in;
  logic [2:0]        count;

  int checks   = 0;
  int failures = 0;

  rob_commit_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .issue_tag   (issue_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .commit      (commit),
    .reg_num     (reg_num),
    .data_in     (data_in),
    .num_in      (num_in),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit iv, input logic [4:0] rd, input bit wv, input logic [2:0] wt,
                       input logic [31:0] wd, input bit fl, input bit rs);
    issue_valid = iv;
    issue_rd    = rd;
    wb_valid    = wv;
    wb_tag      = wt;
    wb_data     = wd;
    flush       = fl;
    rst         = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 5'd0, 0, 3'd0, 32'd0, 0, 0);
  endtask

  task automatic do_reset();
    drive(0, 5'd0, 0, 3'd0, 32'd0, 0, 1);
    tick();
    idle();
  endtask

  task automatic test_reset();
    drive(1, 5'd9, 1, 3'd1, 32'hDEAD, 0, 1);
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL rst_issue_ready got=%0b exp=0", issue_ready); end
    tick();
    idle();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL rst_commit got=%0b exp=0", commit); end
    checks++; if (reg_num !== 5'd0 || data_in !== 32'd0 || num_in !== 3'd0) begin
      failures++; $display("FAIL rst_outputs got reg=%0d data=%h num=%0d exp all 0", reg_num, data_in, num_in); end
    checks++; if (issue_tag !== 3'd1) begin failures++; $display("FAIL rst_issue_tag got=%0d exp=1", issue_tag); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%0b exp=1", issue_ready); end
  endtask

  task automatic test_issue_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(5 + i), 0, 3'd0, 32'd0, 0, 0);
      checks++; if (issue_tag !== 3'(i + 1)) begin failures++; $display("FAIL issue_tag_%0d got=%0d exp=%0d", i, issue_tag, i + 1); end
      tick();
      checks++; if (commit !== 1'b0) begin failures++; $display("FAIL issue_no_commit_%0d got=%0b exp=0", i, commit); end
    end
    idle();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL issue_count got=%0d exp=3", count); end
  endtask

  task automatic test_out_of_order_wb();
    int s;
    bit exp_c;
    s = BYPASS ? 0 : 1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(5 + i), 0, 3'd0, 32'd0, 0, 0);
      tick();
    end
    drive(0, 5'd0, 1, 3'd2, 32'hAA, 0, 0);
    tick();
    checks++; if (commit !== 1'b0) begin failures++; $display("FAIL ooo_early_commit got=%0b exp=0", commit); end
    drive(0, 5'd0, 1, 3'd1, 32'h11, 0, 0);
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      exp_c = (c == s) || (c == s + 1);
      checks++; if (commit !== exp_c) begin failures++; $display("FAIL ooo_commit_c%0d got=%0b exp=%0b", c, commit, exp_c); end
      if (c == s) begin
        checks++; if (reg_num !== 5'd5 || data_in !== 32'h11 || num_in !== 3'd1) begin
          failures++; $display("FAIL ooo_first got reg=%0d data=%h num=%0d exp reg=5 data=11 num=1", reg_num, data_in, num_in); end
      end
      if (c == s + 1) begin
        checks++; if (reg_num !== 5'd6 || data_in !== 32'hAA || num_in !== 3'd2) begin
          failures++; $display("FAIL ooo_second got reg=%0d data=%h num=%0d exp reg=6 data=aa num=2", reg_num, data_in, num_in); end
      end
      tick();
    end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL ooo_count got=%0d exp=1", count); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, 5'(i + 1), 0, 3'd0, 32'd0, 0, 0);
      tick();
    end
    drive(1, 5'd9, 1, 3'd1, 32'h77, 0, 0);
    checks++; if (count !== 3'd7) begin failures++; $display("FAIL full_count got=%0d exp=7", count); end
    for (int k = 0; k < 4 && count == 3'd7; k++) begin
      checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL full_ready_k%0d got=%0b exp=0", k, issue_ready); end
      tick();
      drive(1, 5'd9, 0, 3'd0, 32'd0, 0, 0);
    end
    checks++; if (count !== 3'd6) begin failures++; $display("FAIL full_after_commit_count got=%0d exp=6", count); end
    checks++; if (commit !== 1'b1 || num_in !== 3'd1 || data_in !== 32'h77) begin
      failures++; $display("FAIL full_commit got c=%0b num=%0d data=%h exp c=1 num=1 data=77", commit, num_in, data_in); end
    checks++; if (issue_ready !== 1'b1 || issue_tag !== 3'd1) begin
      failures++; $display("FAIL full_wrap_tag got rdy=%0b tag=%0d exp rdy=1 tag=1", issue_ready, issue_tag); end
    tick();
    idle();
    checks++; if (count !== 3'd7 || issue_tag !== 3'd2) begin
      failures++; $display("FAIL full_refill got count=%0d tag=%0d exp count=7 tag=2", count, issue_tag); end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 5'd0, 0, 3'd0, 32'd0, 0, 0);
    tick();
    drive(0, 5'd0, 1, 3'd1, 32'h33, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      idle();
      checks++; if (commit !== 1'b0) begin failures++; $display("FAIL x0_commit_c%0d got=%0b exp=0", c, commit); end
    end
    checks++; if (count !== 3'd0 || issue_tag !== 3'd2) begin
      failures++; $display("FAIL x0_retire got count=%0d tag=%0d exp count=0 tag=2", count, issue_tag); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(10 + i), 0, 3'd0, 32'd0, 0, 0);
      tick();
    end
    drive(0, 5'd0, 1, 3'd2, 32'h22, 0, 0);
    tick();
    drive(1, 5'd20, 1, 3'd1, 32'h44, 1, 0);
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", issue_ready); end
    tick();
    idle();
    checks++; if (count !== 3'd0 || issue_tag !== 3'd1 || issue_ready !== 1'b1) begin
      failures++; $display("FAIL flush_state got count=%0d tag=%0d rdy=%0b exp 0/1/1", count, issue_tag, issue_ready); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (commit !== 1'b0) begin failures++; $display("FAIL flush_commit_c%0d got=%0b exp=0", c, commit); end
      tick();
    end
  endtask

  task automatic test_wb_latency();
    int lat;
    bit exp_c;
    lat = BYPASS ? 1 : 2;
    do_reset();
    drive(1, 5'd3, 0, 3'd0, 32'd0, 0, 0);
    tick();
    drive(0, 5'd0, 1, 3'd1, 32'h5, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      idle();
      exp_c = (c == lat);
      checks++; if (commit !== exp_c) begin failures++; $display("FAIL lat_commit_c%0d got=%0b exp=%0b", c, commit, exp_c); end
      if (exp_c) begin
        checks++; if (data_in !== 32'h5 || reg_num !== 5'd3) begin
          failures++; $display("FAIL lat_data got data=%h reg=%0d exp data=5 reg=3", data_in, reg_num); end
      end
    end
  endtask

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rd;
    bit          ready;
    logic [31:0] data;
  } m_ent_t;

  task automatic test_random();
    m_ent_t      mq[$];
    logic [2:0]  m_tail;
    bit          m_commit;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [2:0]  m_num;
    bit          iv, wv, fl, rs, exp_ready, retire;
    logic [4:0]  rd, rrd;
    logic [2:0]  wt, rtag;
    logic [31:0] wd, rdata;
    int          r;

    do_reset();
    m_tail = 3'd1; m_commit = 0; m_reg = '0; m_data = '0; m_num = '0;
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 199);
      rs = (r == 0);
      fl = (r >= 1 && r <= 3);
      iv = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wv = ($urandom_range(0, 1) == 1);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) wt = mq[$urandom_range(0, mq.size() - 1)].tag;
      else wt = 3'($urandom_range(0, 7));
      wd = $urandom;
      drive(iv, rd, wv, wt, wd, fl, rs);

      exp_ready = (mq.size() < 7) && !fl && !rs;
      checks++; if (issue_ready !== exp_ready || issue_tag !== m_tail) begin
        failures++; $display("FAIL rnd_issue n=%0d got rdy=%0b tag=%0d exp rdy=%0b tag=%0d", n, issue_ready, issue_tag, exp_ready, m_tail); end

      if (rs) begin
        mq.delete(); m_tail = 3'd1; m_commit = 0; m_reg = '0; m_data = '0; m_num = '0;
      end else if (fl) begin
        mq.delete(); m_tail = 3'd1; m_commit = 0;
      end else begin
        retire = 0; rdata = '0; rrd = '0; rtag = '0;
        if (mq.size() > 0) begin
          rrd  = mq[0].rd;
          rtag = mq[0].tag;
          if (BYPASS && wv && wt == mq[0].tag) begin retire = 1; rdata = wd; end
          else if (mq[0].ready) begin retire = 1; rdata = mq[0].data; end
        end
        if (wv && wt != 3'd0) begin
          foreach (mq[k]) if (mq[k].tag == wt) begin mq[k].ready = 1; mq[k].data = wd; end
        end
        if (retire) void'(mq.pop_front());
        if (iv && exp_ready) begin
          mq.push_back('{tag: m_tail, rd: rd, ready: 1'b0, data: 32'd0});
          m_tail = (m_tail == 3'd7) ? 3'd1 : m_tail + 3'd1;
        end
        m_commit = retire && (rrd != 5'd0);
        if (m_commit) begin m_reg = rrd; m_data = rdata; m_num = rtag; end
      end

      tick();
      checks++; if (commit !== m_commit || count !== 3'(mq.size())) begin
        failures++; $display("FAIL rnd_state n=%0d got c=%0b cnt=%0d exp c=%0b cnt=%0d", n, commit, count, m_commit, mq.size()); end
      checks++; if (reg_num !== m_reg || data_in !== m_data || num_in !== m_num) begin
        failures++; $display("FAIL rnd_commit_port n=%0d got reg=%0d data=%h num=%0d exp reg=%0d data=%h num=%0d",
                             n, reg_num, data_in, num_in, m_reg, m_data, m_num); end
    end
  endtask

  initial begin
    test_reset();
    test_issue_order();
    test_out_of_order_wb();
    test_full_wrap();
    test_x0();
    test_flush();
    test_wb_latency();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
